// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer for the 5-stage core.
// Merges dmem wait, branch flush, mul/div occupancy, load-use stall and imem wait
// into per-register enable/flush strobes, and keeps saturating perf counters.
module pipeline_stall_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             md_busy,
    output logic [1:0]       ctl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned MdCntW = $clog2(MD_LATENCY);
    localparam logic [MdCntW-1:0] MdLoad = MdCntW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMdWait = 2'd1
    } state_e;

    state_e            state_q, state_d;
    logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

    logic md_issue;
    logic br_flush;
    logic md_stall;

    // A branch in EX outranks a mul/div issue; the mul/div only starts when actually served.
    assign md_issue = (state_q == StRun) && md_start && !branch_taken;
    assign br_flush = !rst && !dmem_busy && (state_q == StRun) && branch_taken;
    assign md_stall = !rst && !dmem_busy &&
                      (md_issue || ((state_q == StMdWait) && (md_cnt_q > MdCntW'(1))));

    assign ctl_state = state_q;

    // State register and mul/div occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state: a dmem wait freezes sequencing; md_cnt==1 is the release cycle
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (!dmem_busy) begin
            case (state_q)
                StRun: begin
                    if (md_issue) begin
                        state_d  = StMdWait;
                        md_cnt_d = MdLoad;
                    end
                end
                StMdWait: begin
                    md_cnt_d = md_cnt_q - MdCntW'(1);
                    if (md_cnt_q == MdCntW'(1)) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d  = StRun;
                    md_cnt_d = '0;
                end
            endcase
        end
    end

    // Strobe outputs, resolved strictly by priority
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b0;
        md_busy      = !rst && ((state_q == StMdWait) || md_issue);
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (dmem_busy) begin
            // whole pipe frozen
        end else if (br_flush) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else if (md_stall) begin
            ex_mem_en    = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_en    = 1'b1;
        end else if (hazard_stall) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else if (imem_busy) begin
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (br_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random stimulus, checked
// every cycle against a forward-counting behavioural model. Two instances share inputs:
// one with 16-bit counters, one with 4-bit counters for saturation.
module tb_pipeline_stall_controller;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst, hazard_stall, branch_taken, md_start, imem_busy, dmem_busy;

    logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a;
    logic        ex_mem_en_a, ex_mem_flush_a, mem_wb_en_a, md_busy_a;
    logic [1:0]  ctl_state_a;
    logic [15:0] stall_a, flush_a;

    logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b;
    logic        ex_mem_en_b, ex_mem_flush_b, mem_wb_en_b, md_busy_b;
    logic [1:0]  ctl_state_b;
    logic [3:0]  stall_b, flush_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: mul/div progress counted forward in served cycles
    bit md_active;
    int md_done;
    int stalls;
    int flushes;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MD_LATENCY(L), .CNT_W(16)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .pc_en        (pc_en_a),
        .if_id_en     (if_id_en_a),
        .if_id_flush  (if_id_flush_a),
        .id_ex_en     (id_ex_en_a),
        .id_ex_flush  (id_ex_flush_a),
        .ex_mem_en    (ex_mem_en_a),
        .ex_mem_flush (ex_mem_flush_a),
        .mem_wb_en    (mem_wb_en_a),
        .md_busy      (md_busy_a),
        .ctl_state    (ctl_state_a),
        .stall_cycles (stall_a),
        .flush_events (flush_a)
    );

    pipeline_stall_controller #(.MD_LATENCY(L), .CNT_W(4)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .pc_en        (pc_en_b),
        .if_id_en     (if_id_en_b),
        .if_id_flush  (if_id_flush_b),
        .id_ex_en     (id_ex_en_b),
        .id_ex_flush  (id_ex_flush_b),
        .ex_mem_en    (ex_mem_en_b),
        .ex_mem_flush (ex_mem_flush_b),
        .mem_wb_en    (mem_wb_en_b),
        .md_busy      (md_busy_b),
        .ctl_state    (ctl_state_b),
        .stall_cycles (stall_b),
        .flush_events (flush_b)
    );

    // Strobe order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
    // ex_mem_flush, mem_wb_en
    wire [7:0] strobes_a = {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a,
                            ex_mem_en_a, ex_mem_flush_a, mem_wb_en_a};
    wire [7:0] strobes_b = {pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b,
                            ex_mem_en_b, ex_mem_flush_b, mem_wb_en_b};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
    task automatic step(input logic r, input logic hz, input logic br, input logic md,
                        input logic im, input logic dm);
        logic [7:0] e;
        bit eb, fe, issue, stall_md;
        rst = r; hazard_stall = hz; branch_taken = br;
        md_start = md; imem_busy = im; dmem_busy = dm;
        @(negedge clk);
        issue    = !md_active && md && !br;
        stall_md = issue || (md_active && (md_done < L - 1));
        fe       = !r && !dm && !md_active && br;
        eb       = !r && (md_active || issue);
        if (r)                      e = 8'h2A;
        else if (dm)                e = 8'h00;
        else if (!md_active && br)  e = 8'hFD;
        else if (stall_md)          e = 8'h07;
        else if (hz)                e = 8'h1D;
        else if (im)                e = 8'h75;
        else                        e = 8'hD5;

        check_eq("strobes", {24'd0, strobes_a}, {24'd0, e});
        check_eq("strobes_cnt4", {24'd0, strobes_b}, {24'd0, e});
        check_eq("md_busy", {31'd0, md_busy_a}, {31'd0, eb});
        if (model_valid) begin
            check_eq("ctl_state", {30'd0, ctl_state_a}, md_active ? 32'd1 : 32'd0);
            check_eq("stall_cycles", {16'd0, stall_a}, sat(stalls, 16));
            check_eq("flush_events", {16'd0, flush_a}, sat(flushes, 16));
            check_eq("stall_cycles_cnt4", {28'd0, stall_b}, sat(stalls, 4));
            check_eq("flush_events_cnt4", {28'd0, flush_b}, sat(flushes, 4));
        end

        @(posedge clk);
        if (r) begin
            md_active   = 1'b0;
            md_done     = 0;
            stalls      = 0;
            flushes     = 0;
            model_valid = 1'b1;
        end else begin
            if (!e[7]) stalls++;
            if (fe) flushes++;
            if (!dm) begin
                if (md_active) begin
                    if (md_done == L - 1) md_active = 1'b0;
                    else md_done++;
                end else if (issue) begin
                    md_active = 1'b1;
                    md_done   = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; hazard_stall = 1'b0; branch_taken = 1'b0;
        md_start = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
        md_active = 1'b0; md_done = 0; stalls = 0; flushes = 0;

        // Reset, then a quiet cycle
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        // Single-cycle load-use stall
        step(0, 1, 0, 0, 0, 0);
        check_eq("hazard_stall_count", {16'd0, stall_a}, 32'd1);
        idle(1);

        // Mul/div pulse, no interference
        step(0, 0, 0, 1, 0, 0);
        idle(5);

        // Mul/div with dmem wait in the middle
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        // Branch beats hazard and imem wait; branch ignored while mul/div holds EX
        step(0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(3);

        // Reset in the middle of a mul/div
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_mid_md_state", {30'd0, ctl_state_a}, 32'd0);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
        check_eq("stall_sat_cnt4", {28'd0, stall_b}, 32'd15);
        step(0, 1, 0, 0, 0, 0);
        check_eq("stall_sat_hold_cnt4", {28'd0, stall_b}, 32'd15);
        for (int i = 0; i < 18; i++) step(0, 0, 1, 0, 0, 0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) < 2),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
